// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS32 boot-time program loader.
// Optional checksum stage is enabled by defining MIPS_LOADER_CKSUM_EN.
package mips_loader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_ADDR = 3'd1,
        HDR_LEN  = 3'd2,
        DATA     = 3'd3,
        CKSUM    = 3'd4,
        START    = 3'd5,
        DONE     = 3'd6,
        ERR      = 3'd7
    } state_t;

    // First byte of each word on the stream lands in bits [31:24].
    localparam bit BYTE0_IS_MSB = 1'b1;

    localparam logic [31:0] CKSUM_SEED = 32'h0000_0000;

endpackage

// File: rtl/mips_byte_packer.sv
// Collects accepted stream bytes into 32-bit words; word_valid marks the
// cycle in which the fourth byte is accepted (word is valid combinationally).
module mips_byte_packer
    import mips_loader_pkg::*;
(
    input  logic        clk1,
    input  logic        rst,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  cnt_reg;
    logic [23:0] shift_reg;

    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt_reg   <= 2'd0;
            shift_reg <= 24'd0;
        end else if (byte_valid) begin
            cnt_reg <= cnt_reg + 2'd1;
            if (BYTE0_IS_MSB)
                shift_reg <= {shift_reg[15:0], byte_data};
            else
                shift_reg <= {byte_data, shift_reg[23:8]};
        end
    end

    // The fourth byte bypasses the register so the word is usable on its accept edge.
    assign word       = BYTE0_IS_MSB ? {shift_reg, byte_data} : {byte_data, shift_reg};
    assign word_valid = byte_valid && (cnt_reg == 2'd3);

endmodule

// File: rtl/mips_prog_loader.sv
// Framed byte-stream program loader for the pipelined MIPS32 core: writes the
// image into memory under cpu_rst, then releases the core with cpu_start.
// Define MIPS_LOADER_CKSUM_EN to require a trailing XOR checksum word.
module mips_prog_loader
    import mips_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_written
);

`ifdef MIPS_LOADER_CKSUM_EN
    localparam state_t AFTER_DATA = CKSUM;
`else
    localparam state_t AFTER_DATA = START;
`endif

    state_t              state_reg;
    logic                accept;
    logic [31:0]         word;
    logic                word_valid;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [31:0]         mem_wdata_reg;
    logic                cpu_rst_reg;
    logic                cpu_start_reg;
    logic                busy_reg;
    logic                done_reg;
    logic [LEN_W-1:0]    words_written_reg;
    logic [LEN_W-1:0]    len_reg;
    logic [LEN_W-1:0]    data_cnt_reg;
`ifdef MIPS_LOADER_CKSUM_EN
    logic                err_reg;
    logic [31:0]         cksum_reg;
`endif

    assign in_ready = !rst && (state_reg inside {IDLE, HDR_ADDR, HDR_LEN, DATA, CKSUM});
    assign accept   = in_valid && in_ready;

    mips_byte_packer u_packer (
        .clk1       (clk1),
        .rst        (rst),
        .byte_valid (accept),
        .byte_data  (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_reg         <= IDLE;
            mem_we_reg        <= 1'b0;
            mem_addr_reg      <= '0;
            mem_wdata_reg     <= 32'd0;
            cpu_rst_reg       <= 1'b1;
            cpu_start_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            words_written_reg <= '0;
            len_reg           <= '0;
            data_cnt_reg      <= '0;
`ifdef MIPS_LOADER_CKSUM_EN
            err_reg           <= 1'b0;
            cksum_reg         <= CKSUM_SEED;
`endif
        end else begin
            mem_we_reg    <= 1'b0;
            cpu_start_reg <= 1'b0;

            // Address and count advance at the end of each strobe cycle.
            if (mem_we_reg) begin
                mem_addr_reg      <= mem_addr_reg + 1'b1;
                words_written_reg <= words_written_reg + 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        busy_reg  <= 1'b1;
                        state_reg <= HDR_ADDR;
                    end
                end
                HDR_ADDR: begin
                    if (word_valid) begin
                        mem_addr_reg <= word[ADDR_W-1:0];
                        state_reg    <= HDR_LEN;
                    end
                end
                HDR_LEN: begin
                    if (word_valid) begin
                        len_reg           <= word[LEN_W-1:0];
                        data_cnt_reg      <= '0;
                        words_written_reg <= '0;
`ifdef MIPS_LOADER_CKSUM_EN
                        cksum_reg         <= CKSUM_SEED;
`endif
                        state_reg <= (word[LEN_W-1:0] == '0) ? AFTER_DATA : DATA;
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        mem_we_reg    <= 1'b1;
                        mem_wdata_reg <= word;
                        data_cnt_reg  <= data_cnt_reg + 1'b1;
`ifdef MIPS_LOADER_CKSUM_EN
                        cksum_reg     <= cksum_reg ^ word;
`endif
                        if (data_cnt_reg + 1'b1 == len_reg)
                            state_reg <= AFTER_DATA;
                    end
                end
`ifdef MIPS_LOADER_CKSUM_EN
                CKSUM: begin
                    if (word_valid) begin
                        if (word == cksum_reg) begin
                            state_reg <= START;
                        end else begin
                            err_reg   <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= ERR;
                        end
                    end
                end
`endif
                START: begin
                    cpu_rst_reg   <= 1'b0;
                    cpu_start_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b1;
                    state_reg     <= DONE;
                end
                DONE: begin
                    if (reload) begin
                        cpu_rst_reg       <= 1'b1;
                        done_reg          <= 1'b0;
                        words_written_reg <= '0;
                        state_reg         <= IDLE;
                    end
                end
                ERR: begin
                    if (reload) begin
`ifdef MIPS_LOADER_CKSUM_EN
                        err_reg <= 1'b0;
`endif
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign mem_we        = mem_we_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_wdata     = mem_wdata_reg;
    assign cpu_rst       = cpu_rst_reg;
    assign cpu_start     = cpu_start_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign words_written = words_written_reg;
`ifdef MIPS_LOADER_CKSUM_EN
    assign err           = err_reg;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mips_prog_loader.sv
// Directed bench for mips_prog_loader: frames are streamed byte by byte and
// every memory write, release pulse and status flag is compared to hand values.
module tb_mips_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        reload = 1'b0;
    logic        in_ready, mem_we, cpu_rst, cpu_start, busy, done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] words_written;

    int          checks = 0;
    int          passes = 0;
    int          fails = 0;
    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          starts = 0;
    int          b2b = 0;
    logic        prev_we = 1'b0;
    logic [31:0] frame_data[16];

    always #5 clk1 = ~clk1;

    mips_prog_loader dut (
        .clk1          (clk1),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .reload        (reload),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .cpu_rst       (cpu_rst),
        .cpu_start     (cpu_start),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .words_written (words_written)
    );

    always @(negedge clk1) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            $display("write addr=%0d data=%h", mem_addr, mem_wdata);
            if (prev_we) b2b++;
        end
        prev_we = mem_we;
        if (cpu_start) begin
            starts++;
            $display("cpu_start pulse at %0t", $time);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the byte's accept edge.
    task automatic send_byte(input logic [7:0] b, input bit gappy);
        if (gappy && $urandom_range(1, 0) == 1) begin
            in_valid = 1'b0;
            @(negedge clk1);
        end
        check("in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gappy);
        for (int i = 0; i < 4; i++)
            send_byte(w[31-8*i -: 8], gappy);
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        starts = 0;
        b2b = 0;
    endtask

    task automatic run_frame(input logic [31:0] base, input int n, input bit gappy);
        logic [31:0] ck;
        ck = 32'd0;
        @(negedge clk1);
        clear_logs();
        send_word(base, gappy);
        send_word(n, gappy);
        for (int i = 0; i < n; i++) begin
            send_word(frame_data[i], gappy);
            ck ^= frame_data[i];
            check("wr_latency_we", {31'd0, mem_we}, 32'd1);
            check("wr_latency_data", mem_wdata, frame_data[i]);
        end
`ifdef MIPS_LOADER_CKSUM_EN
        send_word(ck, gappy);
`endif
        in_valid = 1'b0;
    endtask

    task automatic check_frame(input logic [9:0] base, input int n);
        for (int k = 0; k < 30 && done !== 1'b1; k++) @(negedge clk1);
        @(negedge clk1);
        check("done", {31'd0, done}, 32'd1);
        check("write_count", wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check("write_addr", {22'd0, wr_addr[i]}, {22'd0, base + 10'(i)});
            check("write_data", wr_data[i], frame_data[i]);
        end
        check("start_pulses", starts, 1);
        check("cpu_start_low", {31'd0, cpu_start}, 32'd0);
        check("cpu_rst_released", {31'd0, cpu_rst}, 32'd0);
        check("busy_clear", {31'd0, busy}, 32'd0);
        check("words_written", {16'd0, words_written}, n);
        check("final_addr", {22'd0, mem_addr}, {22'd0, base + 10'(n)});
        check("no_back_to_back", b2b, 0);
        check("ready_in_done", {31'd0, in_ready}, 32'd0);
        check("err_low", {31'd0, err}, 32'd0);
    endtask

    task automatic do_reload();
        @(negedge clk1);
        reload = 1'b1;
        @(negedge clk1);
        reload = 1'b0;
        check("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("reload_done", {31'd0, done}, 32'd0);
        check("reload_err", {31'd0, err}, 32'd0);
        check("reload_words", {16'd0, words_written}, 32'd0);
        check("reload_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
        check({tag, "_mem_we"},    {31'd0, mem_we},    32'd0);
        check({tag, "_mem_addr"},  {22'd0, mem_addr},  32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,          32'd0);
        check({tag, "_cpu_rst"},   {31'd0, cpu_rst},   32'd1);
        check({tag, "_cpu_start"}, {31'd0, cpu_start}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},      32'd0);
        check({tag, "_done"},      {31'd0, done},      32'd0);
        check({tag, "_err"},       {31'd0, err},       32'd0);
        check({tag, "_words"},     {16'd0, words_written}, 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk1);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk1);
        check("idle_ready", {31'd0, in_ready}, 32'd1);

        // Factorial program at address 0
        frame_data[0]  = 32'h280a00c8;
        frame_data[1]  = 32'h28020001;
        frame_data[2]  = 32'h0e94a000;
        frame_data[3]  = 32'h21430000;
        frame_data[4]  = 32'h0e94a000;
        frame_data[5]  = 32'h14431000;
        frame_data[6]  = 32'h2c630001;
        frame_data[7]  = 32'h0e94a000;
        frame_data[8]  = 32'h3460fffc;
        frame_data[9]  = 32'h2542fffe;
        frame_data[10] = 32'hfc000000;
        run_frame(32'h0, 11, 1'b0);
        check("busy_during_frame", {31'd0, busy}, 32'd1);
        check("cpu_rst_during_frame", {31'd0, cpu_rst}, 32'd1);
        check_frame(10'd0, 11);

        // A byte offered in DONE must be refused; a misaligned next frame would expose it
        in_valid = 1'b1;
        in_data  = 8'hEE;
        @(negedge clk1);
        in_valid = 1'b0;
        check("done_holds", {31'd0, done}, 32'd1);

        // Address wrap 1022, 1023, 0
        do_reload();
        frame_data[0] = 32'h11111111;
        frame_data[1] = 32'h22222222;
        frame_data[2] = 32'h33333333;
        run_frame(32'h0000_03FE, 3, 1'b0);
        check_frame(10'd1022, 3);

        // Empty frame
        do_reload();
        run_frame(32'h0000_0123, 0, 1'b0);
        check_frame(10'h123, 0);

        // Reset after 2 of 5 data words
        do_reload();
        @(negedge clk1);
        clear_logs();
        send_word(32'h0000_0100, 1'b0);
        send_word(32'd5, 1'b0);
        send_word(32'hDEAD0001, 1'b0);
        send_word(32'hDEAD0002, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk1);
        check_reset_values("abort");
        rst = 1'b0;
        repeat (3) @(negedge clk1);
        check("abort_write_count", wr_addr.size(), 2);
        check("abort_addr1", {22'd0, wr_addr[1]}, 32'h101);
        check("abort_data1", wr_data[1], 32'hDEAD0002);
        check("abort_no_start", starts, 0);

        // Gappy valid on a 4-word frame
        frame_data[0] = 32'h01234567;
        frame_data[1] = 32'h89ABCDEF;
        frame_data[2] = 32'hCAFEF00D;
        frame_data[3] = 32'h0BADBEEF;
        run_frame(32'h0000_0020, 4, 1'b1);
        check_frame(10'h020, 4);

`ifdef MIPS_LOADER_CKSUM_EN
        // Wrong checksum, then correct one after reload
        do_reload();
        @(negedge clk1);
        clear_logs();
        send_word(32'h0000_0040, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'hA5A5A5A5, 1'b0);
        send_word(32'h0F0F0F0F, 1'b0);
        send_word(32'h00000000, 1'b0);
        in_valid = 1'b0;
        for (int k = 0; k < 20 && err !== 1'b1; k++) @(negedge clk1);
        repeat (3) @(negedge clk1);
        check("ck_err", {31'd0, err}, 32'd1);
        check("ck_no_start", starts, 0);
        check("ck_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check("ck_done_low", {31'd0, done}, 32'd0);
        check("ck_writes", wr_addr.size(), 2);
        check("ck_ready", {31'd0, in_ready}, 32'd0);
        do_reload();
        frame_data[0] = 32'hA5A5A5A5;
        frame_data[1] = 32'h0F0F0F0F;
        run_frame(32'h0000_0040, 2, 1'b0);
        check_frame(10'h040, 2);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
